// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack handshake
// into a small FIFO and presents the head instruction, its PC, PC+4 and
// opcode to decode. Redirects flush the FIFO and kill any in-flight fetch.
module instruction_fetch_unit #(
  parameter int unsigned                DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]      RESET_PC   = 32'h0040_0000,
  parameter int unsigned                DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic [5:0]            opcode_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    S_FETCH   = 1'b0,
    S_DISCARD = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_req;
  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_mem_instr [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_pc    [DEPTH];

  logic                  w_valid;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_room;
  logic [CW-1:0]         w_count_nxt;
  logic [DATA_WIDTH-1:0] w_redir_pc;

  assign w_valid    = (r_count != '0);
  assign w_redir_pc = redirect_pc_i & ~DATA_WIDTH'(3);
  // ack only counts while a request is actually presented in FETCH
  assign w_push     = (r_state == S_FETCH) && r_req && imem_ack_i && !redirect_i;
  assign w_pop      = w_valid && instr_ready_i && !redirect_i;

  // Occupancy after this cycle's push/pop; the outstanding request reserves a slot
  always_comb begin
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    w_room      = (w_count_nxt < CW'(DEPTH));
  end

  // Fetch FSM, PC, request and FIFO pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_req      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_fetch_pc <= w_redir_pc;
      case (r_state)
        S_FETCH: begin
          if (r_req && !imem_ack_i) begin
            r_state <= S_DISCARD;
            r_req   <= 1'b0;
          end else begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end
        end
        default: begin
          // A redirect landing on the killed request's ack has nothing left
          // to wait for, so fetch restarts at the new PC straight away.
          if (imem_ack_i) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end else begin
            r_state <= S_DISCARD;
            r_req   <= 1'b0;
          end
        end
      endcase
    end else begin
      r_count <= w_count_nxt;
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + AW'(1);
        r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case (r_state)
        S_FETCH: begin
          r_req <= (r_req && !imem_ack_i) || w_room;
        end
        default: begin
          if (imem_ack_i) begin
            r_state <= S_FETCH;
            r_req   <= w_room;
          end else begin
            r_req   <= 1'b0;
          end
        end
      endcase
    end
  end

  // FIFO storage; contents are masked by the count, so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= imem_rdata_i;
      r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
    end
  end

  assign imem_req_o    = r_req;
  assign imem_addr_o   = r_fetch_pc;
  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? r_mem_instr[r_rd_ptr] : '0;
  assign instr_pc_o    = w_valid ? r_mem_pc[r_rd_ptr] : '0;
  assign pc_plus4_o    = instr_pc_o + DATA_WIDTH'(4);
  assign opcode_o      = instr_o[DATA_WIDTH-1 -: 6];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: cycle table plus hand sequences
// for redirect and reset corner cases.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] pc_plus4_o;
  logic [5:0]  opcode_o;

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch_unit #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0040_0000),
    .DEPTH      (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .opcode_o      (opcode_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic ack, logic [31:0] rdata, logic redir,
                              logic [31:0] rpc, logic rdy, logic e_req, logic [31:0] e_addr,
                              logic e_valid, logic [31:0] e_instr, logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs away from the active edge, then let outputs settle
  task automatic cyc(input logic rst, input logic ack, input logic [31:0] rdata,
                     input logic redir, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    reset = rst; imem_ack_i = ack; imem_rdata_i = rdata;
    redirect_i = redir; redirect_pc_i = rpc; instr_ready_i = rdy;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_instr,
                            input logic [31:0] e_pc);
    logic [31:0] e_p4;
    logic [31:0] e_op;
    e_p4 = e_pc + 32'd4;
    e_op = {26'd0, e_instr[31:26]};
    chk({tag, "_req"},    {31'd0, imem_req_o},    {31'd0, e_req});
    chk({tag, "_addr"},   imem_addr_o,            e_addr);
    chk({tag, "_valid"},  {31'd0, instr_valid_o}, {31'd0, e_valid});
    chk({tag, "_instr"},  instr_o,                e_instr);
    chk({tag, "_pc"},     instr_pc_o,             e_pc);
    chk({tag, "_pc4"},    pc_plus4_o,             e_p4);
    chk({tag, "_opcode"}, {26'd0, opcode_o},      e_op);
  endtask

  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam logic [31:0] I0  = 32'h0C10_0010;  // jal, opcode 3
  localparam logic [31:0] I1  = 32'h8C22_0004;  // lw, opcode 0x23
  localparam logic [31:0] I2  = 32'h0022_1820;  // add, opcode 0
  localparam logic [31:0] A0  = 32'h2008_0005;  // addi
  localparam logic [31:0] A1  = 32'h1000_FFFF;  // beq
  localparam logic [31:0] A2  = 32'h0810_0000;  // j
  localparam logic [31:0] B0  = 32'h2442_0001;  // addiu
  localparam logic [31:0] C0  = 32'h0C10_0040;  // jal

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; imem_ack_i = 1'b0; imem_rdata_i = '0;
    redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;

    //          rst ack rdata         rdr rpc rdy  req addr       vld instr pc
    // In-order fetch with ack in the first request cycle, ready=1
    tbl.push_back(mk(1, 0, 0,   0, 0, 0,   0, RPC,       0, 0,  0));
    tbl.push_back(mk(0, 0, 0,   0, 0, 1,   0, RPC,       0, 0,  0));
    tbl.push_back(mk(0, 1, I0,  0, 0, 1,   1, RPC,       0, 0,  0));
    tbl.push_back(mk(0, 1, I1,  0, 0, 1,   1, RPC+4,     1, I0, RPC));
    tbl.push_back(mk(0, 1, I2,  0, 0, 1,   1, RPC+8,     1, I1, RPC+4));
    tbl.push_back(mk(0, 0, 0,   0, 0, 1,   1, RPC+12,    1, I2, RPC+8));
    tbl.push_back(mk(0, 0, 0,   0, 0, 1,   1, RPC+12,    0, 0,  0));
    // Back-pressure: reset (async, req drops at once), fill with ready=0
    tbl.push_back(mk(1, 0, 0,   0, 0, 0,   0, RPC,       0, 0,  0));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,   0, RPC,       0, 0,  0));
    tbl.push_back(mk(0, 1, A0,  0, 0, 0,   1, RPC,       0, 0,  0));
    tbl.push_back(mk(0, 1, A1,  0, 0, 0,   1, RPC+4,     1, A0, RPC));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,   0, RPC+8,     1, A0, RPC));
    // stray ack while req=0 must be ignored
    tbl.push_back(mk(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, RPC+8, 1, A0, RPC));
    tbl.push_back(mk(0, 0, 0,   0, 0, 1,   0, RPC+8,     1, A0, RPC));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,   1, RPC+8,     1, A1, RPC+4));
    // push and pop together at count = DEPTH-1
    tbl.push_back(mk(0, 1, A2,  0, 0, 1,   1, RPC+8,     1, A1, RPC+4));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,   1, RPC+12,    1, A2, RPC+8));

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].ack, tbl[i].rdata, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
      expect_out($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr,
                 tbl[i].e_valid, tbl[i].e_instr, tbl[i].e_pc);
    end

    // Redirect while a request is pending; the killed ack comes 3 cycles later
    cyc(1, 0, 0, 0, 0, 0);
    expect_out("rd_rst", 0, RPC, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_out("rd_rel", 0, RPC, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h0040_0100, 0);
    expect_out("rd_pend", 1, RPC, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_out("rd_disc1", 0, 32'h0040_0100, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_out("rd_disc2", 0, 32'h0040_0100, 0, 0, 0);
    cyc(0, 1, 32'hBADB_AD00, 0, 0, 0);
    expect_out("rd_kack", 0, 32'h0040_0100, 0, 0, 0);
    cyc(0, 1, B0, 0, 0, 0);
    expect_out("rd_newreq", 1, 32'h0040_0100, 0, 0, 0);

    // Redirect coincident with an ack while one entry is queued; pc[1:0] ignored
    cyc(0, 1, 32'hFFFF_FFFF, 1, 32'h0040_0203, 0);
    expect_out("ra_head", 1, 32'h0040_0104, 1, B0, 32'h0040_0100);
    cyc(0, 0, 0, 0, 0, 0);
    expect_out("ra_flush", 1, 32'h0040_0200, 0, 0, 0);
    // ready with an empty FIFO must not pop anything
    cyc(0, 1, C0, 0, 0, 1);
    expect_out("ra_req", 1, 32'h0040_0200, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_out("ra_jal", 1, 32'h0040_0204, 1, C0, 32'h0040_0200);
    chk("ra_jal_op3", {26'd0, opcode_o}, 32'h3);

    // Reset with an entry queued and a request pending: outputs clear at once
    cyc(1, 0, 0, 0, 0, 0);
    expect_out("rs_async", 0, RPC, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_out("rs_rel", 0, RPC, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_out("rs_req", 1, RPC, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
